// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, coordinate type and total-count helper
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with next-state active/sync decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int CNT_W  = 10,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0
) (
  input  logic             clk,
  input  logic             tick,
  input  logic             clear,
  output logic [CNT_W-1:0] count_nxt,
  output logic             active_nxt,
  output logic             sync_nxt,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG  = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count;

  always_comb begin
    wrap      = tick && (count == LAST);
    count_nxt = count;
    if (clear)
      count_nxt = '0;
    else if (wrap)
      count_nxt = '0;
    else if (tick)
      count_nxt = count + 1'b1;
  end

  // Decoded from the next count so the top can register it alongside the count itself
  always_comb begin
    active_nxt = (count_nxt < ACT_END);
    if ((count_nxt >= SYNC_BEG) && (count_nxt < SYNC_END))
      sync_nxt = POL;
    else
      sync_nxt = !POL;
  end

  always_ff @(posedge clk) begin
    count <= count_nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with prescaler and strobes
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIX_DIV  = 1,
  parameter int CNT_W    = 10
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] X_PIX,
  output logic [CNT_W-1:0] Y_PIX,
  output logic             Video_On,
  output logic             HSync,
  output logic             VSync,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] PRE_MAX = 5'(PIX_DIV - 1);

  state_t           state, state_nxt;
  logic [4:0]       presc, presc_nxt;
  logic             clear, px_tick, run_nxt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_act_nxt, v_act_nxt, h_sync_nxt, v_sync_nxt;
  logic             h_wrap, v_wrap;
  logic             line_nxt, frame_nxt;

  always_ff @(posedge sclk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = 1'b0;
    if (reset || !enable)
      state_nxt = IDLE;
    else
      state_nxt = RUN;
    run_nxt = (state_nxt == RUN);
  end

  // Counters hold at zero through IDLE and on the edge that enters RUN
  assign clear   = reset || !enable || (state == IDLE);
  assign px_tick = !clear && (presc == PRE_MAX);

  always_comb begin
    presc_nxt = presc;
    if (clear || (presc == PRE_MAX))
      presc_nxt = '0;
    else
      presc_nxt = presc + 1'b1;
  end

  always_ff @(posedge sclk) begin
    presc <= presc_nxt;
  end

  vga_axis_counter #(
    .CNT_W (CNT_W),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .POL   (H_POL)
  ) u_h_axis (
    .clk       (sclk),
    .tick      (px_tick),
    .clear     (clear),
    .count_nxt (h_nxt),
    .active_nxt(h_act_nxt),
    .sync_nxt  (h_sync_nxt),
    .wrap      (h_wrap)
  );

  vga_axis_counter #(
    .CNT_W (CNT_W),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .POL   (V_POL)
  ) u_v_axis (
    .clk       (sclk),
    .tick      (h_wrap),
    .clear     (clear),
    .count_nxt (v_nxt),
    .active_nxt(v_act_nxt),
    .sync_nxt  (v_sync_nxt),
    .wrap      (v_wrap)
  );

  // Pixel 0 of a line is reached either by entering RUN or by the horizontal wrap
  assign line_nxt  = run_nxt && ((state == IDLE) || h_wrap);
  assign frame_nxt = run_nxt && ((state == IDLE) || v_wrap);

  always_ff @(posedge sclk) begin
    if (reset || !run_nxt) begin
      X_PIX       <= '0;
      Y_PIX       <= '0;
      Video_On    <= 1'b0;
      HSync       <= !H_POL;
      VSync       <= !V_POL;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      X_PIX       <= h_nxt;
      Y_PIX       <= v_nxt;
      Video_On    <= h_act_nxt && v_act_nxt;
      HSync       <= h_sync_nxt;
      VSync       <= v_sync_nxt;
      pix_tick    <= (presc_nxt == '0);
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
    end
  end

endmodule
